// File: rtl/ky32_muldiv_if.sv
// Request/result bundle between the KY32 execute stage and the multiply/divide unit.
// The execute stage drives the master side; ky32_muldiv sits on the slave side.
interface ky32_muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/ky32_muldiv.sv
// Iterative 32-bit multiply/divide unit: 32 RUN cycles plus one FIX cycle per op.
// Define KY32_MULDIV_DIV_EN to build the restoring divider; otherwise DIVU/DIV return zero.
module ky32_muldiv (
  input  logic         clk,
  input  logic         rst,
  ky32_muldiv_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  cnt;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic [31:0] opnd;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        is_div;
  logic        neg_res;
  logic        done_q;
`ifdef KY32_MULDIV_DIV_EN
  logic        neg_rem;
  logic        div_zero;
  logic [31:0] a_raw;
  logic [32:0] shifted;
  logic        ge;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
`endif

  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] sum;
  logic [31:0] mul_hi;
  logic [31:0] mul_lo;
  logic [63:0] prod;
  logic [63:0] prod_fix;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Signed ops work on magnitudes; the sign is restored once in FIX.
  always_comb begin
    a_neg = bus.op[0] & bus.a[31];
    b_neg = bus.op[0] & bus.b[31];
    abs_a = a_neg ? 32'd0 - bus.a : bus.a;
    abs_b = b_neg ? 32'd0 - bus.b : bus.b;
  end

  // {p_hi,p_lo} shifts right each cycle, consuming the multiplier from p_lo[0].
  always_comb begin
    sum    = {1'b0, p_hi} + {1'b0, opnd};
    mul_hi = p_lo[0] ? sum[32:1] : {1'b0, p_hi[31:1]};
    mul_lo = {(p_lo[0] ? sum[0] : p_hi[0]), p_lo[31:1]};
  end

`ifdef KY32_MULDIV_DIV_EN
  // Partial remainder in p_hi, dividend shifting out of p_lo as quotient bits shift in.
  always_comb begin
    shifted = {p_hi, p_lo[31]};
    ge      = shifted >= {1'b0, opnd};
    div_hi  = ge ? shifted[31:0] - opnd : shifted[31:0];
    div_lo  = {p_lo[30:0], ge};
  end
`endif

  always_comb begin
    prod     = {p_hi, p_lo};
    prod_fix = neg_res ? 64'd0 - prod : prod;
    res_hi   = prod_fix[63:32];
    res_lo   = prod_fix[31:0];
    if (is_div) begin
`ifdef KY32_MULDIV_DIV_EN
      if (div_zero) begin
        res_hi = a_raw;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = neg_rem ? 32'd0 - p_hi : p_hi;
        res_lo = neg_res ? 32'd0 - p_lo : p_lo;
      end
`else
      res_hi = 32'd0;
      res_lo = 32'd0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch on accept, one iteration per RUN cycle, publish result in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 5'd0;
      p_hi    <= 32'd0;
      p_lo    <= 32'd0;
      opnd    <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      done_q  <= 1'b0;
`ifdef KY32_MULDIV_DIV_EN
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= 32'd0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt     <= 5'd0;
            p_hi    <= 32'd0;
            is_div  <= bus.op[1];
            neg_res <= a_neg ^ b_neg;
`ifdef KY32_MULDIV_DIV_EN
            neg_rem  <= a_neg;
            div_zero <= (bus.b == 32'd0);
            a_raw    <= bus.a;
            if (bus.op[1]) begin
              p_lo <= abs_a;
              opnd <= abs_b;
            end else begin
              p_lo <= abs_b;
              opnd <= abs_a;
            end
`else
            p_lo <= abs_b;
            opnd <= abs_a;
`endif
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
`ifdef KY32_MULDIV_DIV_EN
          if (is_div) begin
            p_hi <= div_hi;
            p_lo <= div_lo;
          end else begin
            p_hi <= mul_hi;
            p_lo <= mul_lo;
          end
`else
          p_hi <= mul_hi;
          p_lo <= mul_lo;
`endif
        end
        FIX: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
